// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding, requester count and
// the pointer value loaded at reset.
package rr_arbiter_8_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  // Reset pointer of 7 makes requester 0 the first to win after reset.
  localparam logic [IdxW-1:0] ResetPtr = 3'd7;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// 3-bit index to 8-bit one-hot decoder.
module decoder_3to8 (
  input  logic [2:0] idx_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = 8'h00;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters. The grant is held until done, a request drop, or
// MAX_HOLD cycles elapse; IDLE is always visited between grants.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  input  logic              done,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned CntW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldSat  = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic [NumReq-1:0] dec_onehot;
  logic              release_now;
  logic              expire;

  // First set bit of r scanning upward from last+1 with wrap; last itself is checked last.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] r,
                                              input logic [IdxW-1:0]   last);
    logic [IdxW-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = last + IdxW'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign release_now = done | ~req[idx_q];
  assign expire      = (MAX_HOLD != 0) && (hold_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          idx_d   = rr_pick(req, idx_q);
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (hold_q != HoldSat) begin
          hold_d = hold_q + 1'b1;
        end
        // An explicit or implicit release wins over the hold limit, suppressing timeout.
        if (release_now) begin
          state_d = StIdle;
        end else if (expire) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= ResetPtr;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  decoder_3to8 u_decoder (
    .idx_i    (idx_q),
    .onehot_o (dec_onehot)
  );

  assign busy      = (state_q == StGrant);
  assign grant     = dec_onehot & {NumReq{busy}};
  assign grant_idx = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a cycle-level reference model queues the expected outputs
// for each edge and a negedge monitor compares them against the DUT.
module tb_rr_arbiter_8;

  localparam int unsigned MaxHold = 4;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] idx;
    logic       busy;
    logic       to;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];

  // Reference model state: whether someone holds the grant, who, for how many cycles so far.
  bit m_granted;
  int m_owner;
  int m_held;
  int m_last;
  bit m_to;

  rr_arbiter_8 #(
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_granted = 1'b0;
    m_owner   = 0;
    m_held    = 0;
    m_last    = 7;
    m_to      = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    obs_t e;
    m_to = 1'b0;
    if (!m_granted) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last + k) % 8;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_last    = m_owner;
        m_granted = 1'b1;
        m_held    = 1;
      end
    end else if (d || !r[m_owner]) begin
      m_granted = 1'b0;
    end else if (m_held == MaxHold) begin
      m_granted = 1'b0;
      m_to      = 1'b1;
    end else begin
      m_held++;
    end
    e.g    = m_granted ? (8'h01 << m_owner) : 8'h00;
    e.idx  = 3'(m_last);
    e.busy = m_granted;
    e.to   = m_to;
    exp_q.push_back(e);
  endtask

  // Drive inputs for one edge, queue the model's prediction, then step past the edge.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_direct(input string name, input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got grant=%h idx=%0d busy=%b timeout=%b, want grant=%h idx=%0d busy=%b timeout=%b",
               name, act.g, act.idx, act.busy, act.to, want.g, want.idx, want.busy, want.to);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.g    = grant;
      a.idx  = grant_idx;
      a.busy = busy;
      a.to   = timeout;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got grant=%h idx=%0d busy=%b timeout=%b, want grant=%h idx=%0d busy=%b timeout=%b",
                 $time, a.g, a.idx, a.busy, a.to, e.g, e.idx, e.busy, e.to);
      end
    end
  end

  initial begin
    obs_t act;
    obs_t rst_exp;
    logic [7:0] r;

    rst_exp.g    = 8'h00;
    rst_exp.idx  = 3'd7;
    rst_exp.busy = 1'b0;
    rst_exp.to   = 1'b0;

    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    #12;
    act = {grant, grant_idx, busy, timeout};
    check_direct("reset_values", act, rst_exp);
    rst_n = 1'b1;

    // Two requesters alternate, requester 0 first.
    cycle(8'h05, 1'b0);
    cycle(8'h05, 1'b1);
    cycle(8'h05, 1'b0);
    cycle(8'h05, 1'b1);
    cycle(8'h05, 1'b0);
    cycle(8'h05, 1'b1);
    cycle(8'h00, 1'b0);

    // Single requester released after three grant cycles.
    cycle(8'h80, 1'b0);
    cycle(8'h80, 1'b0);
    cycle(8'h80, 1'b0);
    cycle(8'h80, 1'b1);
    cycle(8'h80, 1'b0);
    cycle(8'h80, 1'b1);
    cycle(8'h00, 1'b0);

    // Hold limit expiry, then re-grant after one dead cycle.
    for (int i = 0; i < 6; i++) cycle(8'h02, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Release coincident with the last permitted cycle: no timeout.
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b1);
    cycle(8'h00, 1'b0);

    // Implicit release by dropping req[4]; requester 5 follows.
    cycle(8'h30, 1'b0);
    cycle(8'h30, 1'b0);
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);
    cycle(8'h00, 1'b0);

    // Randomised traffic.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'h01 << $urandom_range(0, 7);
        2: r = 8'($urandom);
        default: ;
      endcase
      cycle(r, ($urandom_range(0, 5) == 0));
    end
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Asynchronous reset while requester 3 holds the grant.
    cycle(8'h08, 1'b0);
    cycle(8'h08, 1'b0);
    @(negedge clk);
    act = {grant, grant_idx, busy, timeout};
    rst_exp.g    = 8'h08;
    rst_exp.idx  = 3'd3;
    rst_exp.busy = 1'b1;
    rst_exp.to   = 1'b0;
    check_direct("grant_before_reset", act, rst_exp);
    #2;
    rst_n = 1'b0;
    #1;
    act = {grant, grant_idx, busy, timeout};
    rst_exp.g    = 8'h00;
    rst_exp.idx  = 3'd7;
    rst_exp.busy = 1'b0;
    check_direct("async_reset", act, rst_exp);
    model_reset();
    req = 8'hFF;
    #1;
    rst_n = 1'b1;
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
